// File: rtl/muldiv_iter_unit.sv
// Iterative signed/unsigned multiply/divide with HI/LO result registers and start/busy/done handshake.
// Divide hardware is included only when MULDIV_DIV_EN is defined.
module muldiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc, w_step;
    logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
    logic               r_div, r_neg_q, r_neg_r, r_dbz;

    logic               w_accept, w_skip, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fix_hi, w_fix_lo;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_accept = start_i && !flush_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_a_neg  = op_i[0] & a_i[WIDTH-1];
    assign w_b_neg  = op_i[0] & b_i[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~a_i + 1'b1) : a_i;
    assign w_b_mag  = w_b_neg ? (~b_i + 1'b1) : b_i;

`ifdef MULDIV_DIV_EN
    assign w_skip = op_i[1] && (b_i == '0);
`else
    // Without divide hardware every divide op completes immediately with no effect.
    assign w_skip = op_i[1];
`endif

    // Accumulator is {upper, lower}; multiply keeps the multiplier in the lower half,
    // divide keeps the remainder in the upper half and shifts quotient bits into the lower.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] w_shl, w_diff;
    assign w_shl  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, r_opnd};

    always_comb begin
        w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        if (r_div) begin
            if (!w_diff[WIDTH])
                w_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_step = {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end
`else
    assign w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif

    assign w_prod_neg = ~r_acc + 1'b1;

    always_comb begin
        if (r_div) begin
            w_fix_lo = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        end else begin
            w_fix_lo = r_neg_q ? w_prod_neg[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_q ? w_prod_neg[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)               w_next = w_skip ? S_DONE : S_RUN;
                else if (r_state == S_DONE) w_next = S_IDLE;
            end
            S_RUN: begin
                if (flush_i)                     w_next = S_IDLE;
                else if (r_cnt == CNT_W'(1))     w_next = S_FIX;
            end
            S_FIX:   w_next = flush_i ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_div   <= op_i[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= CNT_W'(WIDTH);
            r_opnd  <= op_i[1] ? w_b_mag : w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, (op_i[1] ? w_a_mag : w_b_mag)};
`ifdef MULDIV_DIV_EN
            r_dbz   <= w_skip;
            if (w_skip) begin
                r_hi <= a_i;
                r_lo <= '1;
            end
`else
            r_dbz   <= 1'b0;
`endif
        end else if (r_state == S_RUN) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == S_FIX && !flush_i) begin
            r_hi  <= w_fix_hi;
            r_lo  <= w_fix_lo;
            r_dbz <= 1'b0;
        end
    end

    assign busy_o        = (r_state == S_RUN) || (r_state == S_FIX);
    assign done_o        = (r_state == S_DONE);
    assign div_by_zero_o = (r_state == S_DONE) && r_dbz;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit; results are checked against a scoreboard on each done_o.
module tb_muldiv_iter_unit;
    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1, start_i = 1'b0, flush_i = 1'b0;
    logic [1:0]   op_i = '0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         busy_o, done_o, div_by_zero_o;
    logic [W-1:0] hi_o, lo_o;

    muldiv_iter_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; logic dbz; int cyc; } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done_o) begin
            if (sb.size() == 0) chk("unexpected_done", 64'(done_o), 64'h0);
            else begin
                e = sb.pop_front();
                chk("hi", 64'(hi_o), 64'(e.hi));
                chk("lo", 64'(lo_o), 64'(e.lo));
                chk("dbz", 64'(div_by_zero_o), 64'(e.dbz));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drives a one-cycle start strobe in the current cycle, then scrambles operands.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input int lat, input bit push);
        exp_t e;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        if (push) begin
            e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start_i = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done_o && n < budget);
        chk("done_seen", 64'(done_o), 64'h1);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] ph, pl;

        @(negedge clk);
        chk("reset_outs", 64'({busy_o, done_o, div_by_zero_o, hi_o}), 64'h0);
        chk("reset_lo", 64'(lo_o), 64'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // MULTU max*max with busy/done timing
        n = cyc;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 1'b1);
        chk("busy_n1", 64'(busy_o), 64'h1);
        at_cyc(n + 33);
        chk("busy_n33", 64'(busy_o), 64'h1);
        chk("nodone_n33", 64'(done_o), 64'h0);
        at_cyc(n + 34);
        chk("busy_n34", 64'(busy_o), 64'h0);
        chk("done_n34", 64'(done_o), 64'h1);

        // MULT -3*5, then back-to-back MULTU issued in the DONE cycle
        @(posedge clk); #1;
        issue(2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 1'b1);
        wait_done(40);
        issue(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 34, 1'b1);
        wait_done(40);

`ifdef MULDIV_DIV_EN
        @(posedge clk); #1;
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
        wait_done(40);
        issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b1);
        wait_done(40);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, 1'b1);
        wait_done(40);
        @(posedge clk); #1;
        issue(2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
        wait_done(3);
`else
        @(posedge clk); #1;
        issue(2'b10, 32'h1234, 32'd0, 32'd0, 32'd42, 1'b0, 1, 1'b1);
        wait_done(3);
        @(posedge clk); #1;
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd42, 1'b0, 1, 1'b1);
        wait_done(3);
`endif

        // flush mid-operation; a start during RUN is ignored
        ph = hi_o; pl = lo_o;
        @(posedge clk); #1;
        n = cyc;
        issue(2'b01, 32'd12345, 32'd678, '0, '0, 1'b0, 0, 1'b0);
        at_cyc(n + 5);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        at_cyc(n + 10);
        chk("busy_before_flush", 64'(busy_o), 64'h1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("busy_after_flush", 64'(busy_o), 64'h0);
        repeat (40) @(negedge clk);
        chk("flush_hi_kept", 64'(hi_o), 64'(ph));
        chk("flush_lo_kept", 64'(lo_o), 64'(pl));

        // flush wins over start in IDLE
        @(posedge clk); #1;
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_blocks_start", 64'(busy_o), 64'h0);

        // asynchronous reset mid-operation
        @(posedge clk); #1;
        n = cyc;
        issue(2'b01, 32'd999, 32'd3, '0, '0, 1'b0, 0, 1'b0);
        at_cyc(n + 20);
        #2 rst = 1'b1;
        #1;
        chk("rst_flags", 64'({busy_o, done_o, div_by_zero_o}), 64'h0);
        chk("rst_hi", 64'(hi_o), 64'h0);
        chk("rst_lo", 64'(lo_o), 64'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 1'b1);
        wait_done(40);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
Parametrised iterative multiply/divide unit for the execute stage; next generation of the existing shift-add multiplier.
- Self-contained datapath; does not borrow the main ALU.
- Supports signed/unsigned multiply and divide with HI/LO result registers.
- Uses a start/busy/done handshake that the hazard unit uses to stall dependent reads of HI/LO.

Parameters:
WIDTH, 32, operand width in bits; HI/LO are WIDTH each.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  in  1  clock
rst  in  1  reset
start_i  in  1  request new operation (single-cycle strobe)
op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a_i  in  WIDTH  operand A (multiplicand / dividend)
b_i  in  WIDTH  operand B (multiplier / divisor)
flush_i  in  1  abort in-flight operation
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
hi_o  out  WIDTH  HI register (product upper half / remainder)
lo_o  out  WIDTH  LO register (product lower half / quotient)
div_by_zero_o  out  1  pulses with done_o for divide with b_i==0

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - State returns to IDLE.
  - busy_o, done_o, div_by_zero_o = 0; hi_o, lo_o = 0.
  - Reset mid-operation discards the operation with no done_o.
- States: IDLE, RUN, FIX, DONE. State is registered; busy_o = (state==RUN || state==FIX); done_o = (state==DONE).
- Acceptance: start_i is sampled only in IDLE or DONE, which allows back-to-back operations. It is ignored in RUN/FIX.
  - On acceptance in cycle N: operands, op and result sign are latched; signed ops convert operands to magnitude; counter = WIDTH; go to RUN.
- RUN: one bit per cycle for WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter decrements each cycle; at 1, go to FIX.
- FIX: one cycle of sign correction.
  - Product negated if signs differ.
  - Quotient negated if signs differ; remainder takes dividend's sign (truncation toward zero).
  - Go to DONE.
- DONE: hi_o/lo_o updated on entry and held until the next completion; done_o high one cycle; next state is IDLE, or RUN if start_i is accepted.
- Latency: start at N -> busy_o high N+1..N+WIDTH+1; done_o and new hi_o/lo_o visible at N+WIDTH+2.
- Divide by zero: detected at acceptance; skips RUN/FIX (IDLE->DONE), so done_o is at N+1.
  - hi_o = a_i, lo_o = all ones, div_by_zero_o = 1 with done_o.
- Signed overflow (DIV MIN / -1): lo_o = MIN, hi_o = 0, no flag.
- flush_i: in RUN/FIX, next state IDLE; no done_o; hi_o/lo_o unchanged. In IDLE/DONE, flush_i suppresses start_i acceptance that cycle (flush wins).
- Operands are captured at acceptance; changes to a_i/b_i afterwards have no effect.

Optional Feature:
MULDIV_DIV_EN
- Defined: divide ops are supported as above.
- Undefined: divide hardware is omitted. op_i[1]==1 is accepted and goes IDLE->DONE, so done_o is at N+1. hi_o/lo_o are unchanged and div_by_zero_o stays 0. Multiply is unaffected.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at N -> busy_o N+1..N+33; done_o at N+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Back-to-back start in the DONE cycle, MULTU 7*6 -> done 34 cycles later, hi=0, lo=42.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0, start at N -> done_o and div_by_zero_o at N+1; hi=0x1234, lo=0xFFFFFFFF. Without MULDIV_DIV_EN -> done at N+1, hi/lo unchanged, flag 0.
- MULT started at N, flush_i at N+10 -> busy_o low at N+11, no done_o, hi/lo keep prior values. start_i at N+5 is ignored.
- rst asserted at N+20 of an operation -> all outputs 0 immediately (asynchronous). After release, a new MULTU 3*4 -> lo=12.
